// File: rtl/trisc_pkg.sv
// Shared TRISC definitions: opcode constants, decoder FSM encoding, line indices.
package trisc_pkg;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_STA = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_INC = 4'b0110;
   localparam logic [3:0] OP_CLR = 4'b0111;
   localparam logic [3:0] OP_JMP = 4'b1000;
   localparam logic [3:0] OP_JPZ = 4'b1001;
   localparam logic [3:0] OP_JPN = 4'b1010;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam int unsigned NUM_LINES = 11;
   localparam int unsigned LINE_LDA  = 0;
   localparam int unsigned LINE_STA  = 1;
   localparam int unsigned LINE_ADD  = 2;
   localparam int unsigned LINE_SUB  = 3;
   localparam int unsigned LINE_XOR  = 4;
   localparam int unsigned LINE_INC  = 5;
   localparam int unsigned LINE_CLR  = 6;
   localparam int unsigned LINE_JMP  = 7;
   localparam int unsigned LINE_JPZ  = 8;
   localparam int unsigned LINE_JPN  = 9;
   localparam int unsigned LINE_HLT  = 10;

   typedef enum logic [1:0] {StEmpty, StLoad, StValid, StHalt} dec_state_t;

   function automatic logic is_reserved(input logic [3:0] op);
      return (op == 4'b0101) || ((op >= 4'b1011) && (op <= 4'b1110));
   endfunction

endpackage

// File: rtl/trisc_opdecode.sv
// Combinational opcode + flags to one-hot line / Skip / Illegal map.
module trisc_opdecode
   import trisc_pkg::*;
(
   input  logic [3:0]           op,
   input  logic                 zflag,
   input  logic                 nflag,
   output logic [NUM_LINES-1:0] lines,
   output logic                 skip,
   output logic                 illegal
);

   always_comb begin
      lines   = '0;
      skip    = 1'b0;
      illegal = 1'b0;
      case (op)
         OP_LDA: lines[LINE_LDA] = 1'b1;
         OP_STA: lines[LINE_STA] = 1'b1;
         OP_ADD: lines[LINE_ADD] = 1'b1;
         OP_SUB: lines[LINE_SUB] = 1'b1;
         OP_XOR: lines[LINE_XOR] = 1'b1;
         OP_INC: lines[LINE_INC] = 1'b1;
         OP_CLR: lines[LINE_CLR] = 1'b1;
         OP_JMP: lines[LINE_JMP] = 1'b1;
         OP_JPZ: begin
            if (zflag) lines[LINE_JPZ] = 1'b1;
            else       skip            = 1'b1;
         end
         OP_JPN: begin
            if (nflag) lines[LINE_JPN] = 1'b1;
            else       skip            = 1'b1;
         end
         OP_HLT: lines[LINE_HLT] = 1'b1;
         default: illegal = is_reserved(op);
      endcase
   end

endmodule

// File: rtl/trisc_decoder.sv
// TRISC instruction register, flag register and registered one-hot decoder.
// Optional TRISC_DECODE_STATS_EN adds saturating InstrCount/IllegalCount outputs.
module trisc_decoder
   import trisc_pkg::*;
#(
   parameter int unsigned OPW = 4,
   parameter int unsigned ADW = 4
) (
   input  logic               SysClock,
   input  logic               Reset,
   input  logic [OPW+ADW-1:0] MemData,
   input  logic               IrLoad,
   input  logic               FlagLoad,
   input  logic               AccZero,
   input  logic               AccNeg,
   output logic               LDA,
   output logic               STA,
   output logic               ADD,
   output logic               SUB,
   output logic               XOR,
   output logic               INC,
   output logic               CLR,
   output logic               JMP,
   output logic               JPZ,
   output logic               JPN,
   output logic               HLT,
   output logic [ADW-1:0]     Operand,
   output logic               Valid,
   output logic               Skip,
   output logic               Illegal,
   output logic               Halted
`ifdef TRISC_DECODE_STATS_EN
   ,
   output logic [7:0]         InstrCount,
   output logic [7:0]         IllegalCount
`endif
);

   dec_state_t             state_q, state_d;
   logic [OPW+ADW-1:0]     ir_q;
   logic                   zflag_q, nflag_q;
   logic [NUM_LINES-1:0]   lines_q, dec_lines;
   logic                   skip_q, illegal_q, dec_skip, dec_illegal;
   logic                   decode_edge;

   trisc_opdecode u_opdecode (
      .op      (ir_q[OPW+ADW-1:ADW]),
      .zflag   (zflag_q),
      .nflag   (nflag_q),
      .lines   (dec_lines),
      .skip    (dec_skip),
      .illegal (dec_illegal)
   );

   assign decode_edge = (state_q == StLoad) && !IrLoad;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StEmpty: if (IrLoad) state_d = StLoad;
         StLoad:  if (!IrLoad) state_d = dec_lines[LINE_HLT] ? StHalt : StValid;
         StValid: if (IrLoad) state_d = StLoad;
         StHalt:  state_d = StHalt;
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge SysClock or posedge Reset) begin
      if (Reset) begin
         state_q   <= StEmpty;
         ir_q      <= '0;
         zflag_q   <= 1'b0;
         nflag_q   <= 1'b0;
         lines_q   <= '0;
         skip_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (FlagLoad) begin
            zflag_q <= AccZero;
            nflag_q <= AccNeg;
         end
         // The HALT state freezes IR and the lines; only Reset leaves it.
         if (state_q != StHalt && IrLoad) begin
            ir_q      <= MemData;
            lines_q   <= '0;
            skip_q    <= 1'b0;
            illegal_q <= 1'b0;
         end else if (decode_edge) begin
            lines_q   <= dec_lines;
            skip_q    <= dec_skip;
            illegal_q <= dec_illegal;
         end
      end
   end

`ifdef TRISC_DECODE_STATS_EN
   logic [7:0] instr_cnt_q, illegal_cnt_q;

   always_ff @(posedge SysClock or posedge Reset) begin
      if (Reset) begin
         instr_cnt_q   <= '0;
         illegal_cnt_q <= '0;
      end else if (decode_edge) begin
         if (instr_cnt_q != 8'hFF) instr_cnt_q <= instr_cnt_q + 8'd1;
         if (dec_illegal && illegal_cnt_q != 8'hFF) illegal_cnt_q <= illegal_cnt_q + 8'd1;
      end
   end

   assign InstrCount   = instr_cnt_q;
   assign IllegalCount = illegal_cnt_q;
`endif

   assign LDA     = lines_q[LINE_LDA];
   assign STA     = lines_q[LINE_STA];
   assign ADD     = lines_q[LINE_ADD];
   assign SUB     = lines_q[LINE_SUB];
   assign XOR     = lines_q[LINE_XOR];
   assign INC     = lines_q[LINE_INC];
   assign CLR     = lines_q[LINE_CLR];
   assign JMP     = lines_q[LINE_JMP];
   assign JPZ     = lines_q[LINE_JPZ];
   assign JPN     = lines_q[LINE_JPN];
   assign HLT     = lines_q[LINE_HLT];
   assign Skip    = skip_q;
   assign Illegal = illegal_q;
   assign Operand = ir_q[ADW-1:0];
   assign Valid   = (state_q == StValid) || (state_q == StHalt);
   assign Halted  = (state_q == StHalt);

endmodule

// File: tb/tb_trisc_decoder.sv
// Randomised self-checking bench for trisc_decoder against a table-driven model.
module tb_trisc_decoder;

   logic       SysClock = 1'b0;
   logic       Reset, IrLoad, FlagLoad, AccZero, AccNeg;
   logic [7:0] MemData;
   logic       LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT;
   logic [3:0] Operand;
   logic       Valid, Skip, Illegal, Halted;
`ifdef TRISC_DECODE_STATS_EN
   logic [7:0] InstrCount, IllegalCount;
   int         m_instr, m_illegal;
`endif

   int tests = 0;
   int fails = 0;
   bit m_z, m_n;

   trisc_decoder dut (
      .SysClock(SysClock), .Reset(Reset), .MemData(MemData), .IrLoad(IrLoad),
      .FlagLoad(FlagLoad), .AccZero(AccZero), .AccNeg(AccNeg),
      .LDA(LDA), .STA(STA), .ADD(ADD), .SUB(SUB), .XOR(XOR), .INC(INC), .CLR(CLR),
      .JMP(JMP), .JPZ(JPZ), .JPN(JPN), .HLT(HLT), .Operand(Operand), .Valid(Valid),
      .Skip(Skip), .Illegal(Illegal), .Halted(Halted)
`ifdef TRISC_DECODE_STATS_EN
      , .InstrCount(InstrCount), .IllegalCount(IllegalCount)
`endif
   );

   always #5 SysClock = ~SysClock;

   // {Illegal, Skip, HLT, JPN, JPZ, JMP, CLR, INC, XOR, SUB, ADD, STA, LDA}
   function automatic logic [12:0] obs();
      return {Illegal, Skip, HLT, JPN, JPZ, JMP, CLR, INC, XOR, SUB, ADD, STA, LDA};
   endfunction

   // Opcode table: line position in obs(), -1 = skipped jump, -2 = reserved.
   function automatic logic [12:0] model(input logic [7:0] ins, input bit z, input bit n);
      int op, idx;
      logic [12:0] r;
      op = int'(ins[7:4]);
      case (op)
         0: idx = 0;   1: idx = 1;   2: idx = 2;   3: idx = 3;
         4: idx = 4;   6: idx = 5;   7: idx = 6;   8: idx = 7;
         9: idx = z ? 8 : -1;
         10: idx = n ? 9 : -1;
         15: idx = 10;
         default: idx = -2;
      endcase
      r = '0;
      if (idx == -1) r[11] = 1'b1;
      else if (idx == -2) r[12] = 1'b1;
      else r[idx] = 1'b1;
      return r;
   endfunction

   task automatic cycle();
      @(posedge SysClock);
      #1;
   endtask

   task automatic apply_reset();
      Reset = 1'b1;
      #2;
      Reset = 1'b0;
      m_z = 0; m_n = 0;
`ifdef TRISC_DECODE_STATS_EN
      m_instr = 0; m_illegal = 0;
`endif
      cycle();
   endtask

   task automatic set_flags(input bit z, input bit n);
      FlagLoad = 1'b1; AccZero = z; AccNeg = n;
      cycle();
      m_z = z; m_n = n;
      FlagLoad = 1'b0;
   endtask

   // Drives a fetch of 'cycles' IrLoad cycles then the decode edge; returns model result.
   task automatic fetch(input logic [7:0] b, input int cycles, input bit fl, input bit z,
                        input bit n, output logic [12:0] exp);
      MemData = b; IrLoad = 1'b1;
      repeat (cycles) cycle();
      IrLoad = 1'b0;
      FlagLoad = fl; AccZero = z; AccNeg = n;
      exp = model(b, m_z, m_n);
`ifdef TRISC_DECODE_STATS_EN
      if (m_instr < 255) m_instr++;
      if (exp[12] && m_illegal < 255) m_illegal++;
`endif
      cycle();
      if (fl) begin m_z = z; m_n = n; end
      FlagLoad = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; IrLoad = 0; FlagLoad = 0; AccZero = 0; AccNeg = 0; MemData = 8'h00;
      #3;
      tests++;
      if ({obs(), Valid, Halted, Operand} !== 19'h0) begin
         fails++; $display("FAIL reset_async: got %h want 0", {obs(), Valid, Halted, Operand});
      end
      Reset = 1'b0;
      repeat (3) cycle();
      tests++;
      if ({obs(), Valid, Halted, Operand} !== 19'h0) begin
         fails++; $display("FAIL reset_idle: got %h want 0", {obs(), Valid, Halted, Operand});
      end
   endtask

   task automatic test_add_hold();
      logic [12:0] e;
      MemData = 8'h2A; IrLoad = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         tests++;
         if (obs() !== 13'h0 || Valid !== 1'b0 || Operand !== 4'hA) begin
            fails++;
            $display("FAIL load_hold[%0d]: lines %h valid %b opnd %h want 0 0 a", i, obs(),
                     Valid, Operand);
         end
      end
      IrLoad = 1'b0;
      e = model(8'h2A, m_z, m_n);
      cycle();
      tests++;
      if (obs() !== e || obs() !== 13'h0004 || Valid !== 1'b1 || Operand !== 4'hA) begin
         fails++;
         $display("FAIL add_decode: lines %h valid %b opnd %h want %h 1 a", obs(), Valid,
                  Operand, e);
      end
   endtask

   task automatic test_cond_jumps();
      logic [12:0] e;
      set_flags(1, 0);
      fetch(8'h95, 1, 0, 0, 0, e);
      tests++;
      if (obs() !== e || !JPZ || Operand !== 4'h5) begin
         fails++; $display("FAIL jpz_taken: got %h opnd %h want %h 5", obs(), Operand, e);
      end
      set_flags(0, 1);
      fetch(8'h95, 2, 0, 0, 0, e);
      tests++;
      if (obs() !== e || Skip !== 1'b1 || Valid !== 1'b1) begin
         fails++; $display("FAIL jpz_skip: got %h valid %b want %h 1", obs(), Valid, e);
      end
      fetch(8'hA7, 1, 0, 0, 0, e);
      tests++;
      if (obs() !== e || JPN !== 1'b1) begin
         fails++; $display("FAIL jpn_taken: got %h want %h", obs(), e);
      end
      set_flags(0, 0);
      fetch(8'h93, 1, 1, 1, 0, e);
      tests++;
      if (obs() !== e || Skip !== 1'b1 || JPZ !== 1'b0) begin
         fails++; $display("FAIL jpz_old_flag: got %h want %h", obs(), e);
      end
      fetch(8'h93, 1, 0, 0, 0, e);
      tests++;
      if (obs() !== e || JPZ !== 1'b1) begin
         fails++; $display("FAIL jpz_new_flag: got %h want %h", obs(), e);
      end
   endtask

   task automatic test_illegal();
      logic [12:0] e;
      apply_reset();
      fetch(8'h5C, 1, 0, 0, 0, e);
      tests++;
      if (obs() !== e || Illegal !== 1'b1 || Valid !== 1'b1 || Operand !== 4'hC) begin
         fails++; $display("FAIL illegal: got %h valid %b want %h 1", obs(), Valid, e);
      end
`ifdef TRISC_DECODE_STATS_EN
      tests++;
      if (InstrCount !== 8'd1 || IllegalCount !== 8'd1) begin
         fails++; $display("FAIL illegal_counts: got %0d %0d want 1 1", InstrCount, IllegalCount);
      end
`endif
   endtask

   task automatic test_random();
      logic [12:0] e;
      logic [7:0]  b;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0) set_flags(1'($urandom), 1'($urandom));
         b = 8'($urandom);
         if (b[7:4] == 4'hF) b[7:4] = 4'($urandom_range(0, 14));
         fetch(b, $urandom_range(1, 3), 1'($urandom), 1'($urandom), 1'($urandom), e);
         tests++;
         if (obs() !== e || Operand !== b[3:0] || Valid !== 1'b1 || Halted !== 1'b0) begin
            fails++;
            $display("FAIL random[%0d] ins %h: lines %h opnd %h valid %b want %h %h 1", i, b,
                     obs(), Operand, Valid, e, b[3:0]);
         end
      end
`ifdef TRISC_DECODE_STATS_EN
      tests++;
      if (InstrCount !== 8'(m_instr) || IllegalCount !== 8'(m_illegal)) begin
         fails++; $display("FAIL random_counts: got %0d %0d want %0d %0d", InstrCount,
                           IllegalCount, m_instr, m_illegal);
      end
`endif
   endtask

   task automatic test_reset_midload();
      MemData = 8'h37; IrLoad = 1'b1;
      cycle();
      Reset = 1'b1;
      #1;
      tests++;
      if ({obs(), Valid, Halted, Operand} !== 19'h0) begin
         fails++; $display("FAIL reset_midload: got %h want 0", {obs(), Valid, Halted, Operand});
      end
      IrLoad = 1'b0;
      Reset = 1'b0;
      m_z = 0; m_n = 0;
`ifdef TRISC_DECODE_STATS_EN
      m_instr = 0; m_illegal = 0;
`endif
      cycle();
   endtask

   task automatic test_halt();
      logic [12:0] e;
      fetch(8'hF3, 1, 0, 0, 0, e);
      repeat (2) cycle();
      tests++;
      if (obs() !== e || Halted !== 1'b1 || Valid !== 1'b1 || Operand !== 4'h3) begin
         fails++; $display("FAIL halt: got %h halted %b want %h 1", obs(), Halted, e);
      end
      MemData = 8'h00; IrLoad = 1'b1; FlagLoad = 1'b1; AccZero = 1'b1;
      repeat (2) cycle();
      IrLoad = 1'b0; FlagLoad = 1'b0;
      repeat (2) cycle();
      tests++;
      if (HLT !== 1'b1 || obs() !== 13'h0400 || Operand !== 4'h3 || Halted !== 1'b1) begin
         fails++; $display("FAIL halt_frozen: got %h opnd %h want 0400 3", obs(), Operand);
      end
      Reset = 1'b1;
      #1;
      tests++;
      if ({obs(), Valid, Halted, Operand} !== 19'h0) begin
         fails++; $display("FAIL halt_reset: got %h want 0", {obs(), Valid, Halted, Operand});
      end
      Reset = 1'b0;
      m_z = 0; m_n = 0;
      cycle();
   endtask

`ifdef TRISC_DECODE_STATS_EN
   task automatic test_stats_saturate();
      logic [12:0] e;
      apply_reset();
      for (int i = 0; i < 260; i++) fetch(8'h10, 1, 0, 0, 0, e);
      tests++;
      if (InstrCount !== 8'hFF || IllegalCount !== 8'h00) begin
         fails++; $display("FAIL instr_saturate: got %h %h want ff 00", InstrCount, IllegalCount);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_add_hold();
      test_cond_jumps();
      test_illegal();
      test_random();
      test_reset_midload();
      test_halt();
`ifdef TRISC_DECODE_STATS_EN
      test_stats_saturate();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
